// File: rtl/zpu_trace_buffer.sv
// zpu_trace_buffer: captures zpu_core retired-instruction records from the
// 137-bit debug bus into a circular FIFO and drains each record as five
// 32-bit words over a valid/ready stream. Records arriving while the FIFO is
// full are dropped, but still consume a sequence number so losses show up as
// gaps. All stream outputs are registered; the next head word is computed
// combinationally from the next-state pointers, with a bypass for a record
// being written into the slot that becomes the head.
module zpu_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstin,
  input  logic [136:0]             dbg_i,
  input  logic                     capture_en,
  input  logic                     clear,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] sp;
    logic [31:0] tos;
    logic [31:0] nos;
    logic [7:0]  inst;
    logic [15:0] seq;
  } rec_t;

  typedef enum logic {ST_EMPTY = 1'b0, ST_SEND = 1'b1} state_t;

  // Select stream word w of a stored record; word 4 carries the marker byte.
  function automatic logic [31:0] word_sel(input rec_t r, input logic [2:0] w);
    logic [31:0] d;
    case (w)
      3'd0:    d = r.pc;
      3'd1:    d = r.sp;
      3'd2:    d = r.tos;
      3'd3:    d = r.nos;
      3'd4:    d = {8'hA5, r.seq, r.inst};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  rec_t            mem_r [DEPTH];
  state_t          state_r, state_s;
  logic [2:0]      widx_r, widx_s;
  logic [AW:0]     wr_ptr_r, wr_ptr_s;
  logic [AW:0]     rd_ptr_r, rd_ptr_s;
  logic [AW:0]     count_r, count_s;
  logic [15:0]     seq_r, seq_s;
  logic            overflow_r, overflow_s;
  logic [31:0]     out_data_r, out_data_s;
  logic            out_valid_r, out_valid_s;
  logic            out_last_r, out_last_s;

  logic            capture_s;
  logic            handshake_s;
  logic            pop_s;
  logic            accept_s;
  logic            drop_s;
  rec_t            new_rec_s;
  rec_t            head_rec_s;
  logic [AW-1:0]   head_idx_s;

  // Event decode: clear masks both capture and pop in the cycle it is high.
  always_comb begin
    capture_s   = dbg_i[136] & capture_en & ~clear;
    handshake_s = out_valid_r & out_ready & ~clear;
    pop_s       = handshake_s & (widx_r == 3'd4);
    accept_s    = capture_s & ((count_r < DEPTH_C) | pop_s);
    drop_s      = capture_s & ~accept_s;
    new_rec_s   = '{pc: dbg_i[31:0], sp: dbg_i[63:32], tos: dbg_i[95:64],
                    nos: dbg_i[127:96], inst: dbg_i[135:128], seq: seq_r};
  end

  // Next-state for pointers, counters, sequence number and overflow flag.
  always_comb begin
    wr_ptr_s   = wr_ptr_r;
    rd_ptr_s   = rd_ptr_r;
    count_s    = count_r;
    seq_s      = seq_r;
    overflow_s = overflow_r;
    widx_s     = widx_r;
    if (clear) begin
      wr_ptr_s   = {(AW+1){1'b0}};
      rd_ptr_s   = {(AW+1){1'b0}};
      count_s    = {(AW+1){1'b0}};
      seq_s      = 16'h0000;
      overflow_s = 1'b0;
      widx_s     = 3'd0;
    end else begin
      wr_ptr_s = wr_ptr_r + (AW+1)'(accept_s);
      rd_ptr_s = rd_ptr_r + (AW+1)'(pop_s);
      count_s  = count_r + (AW+1)'(accept_s) - (AW+1)'(pop_s);
      if (capture_s) begin
        seq_s = seq_r + 16'h0001;
      end else begin
        seq_s = seq_r;
      end
      if (drop_s) begin
        overflow_s = 1'b1;
      end else begin
        overflow_s = overflow_r;
      end
      if (handshake_s) begin
        if (widx_r == 3'd4) begin
          widx_s = 3'd0;
        end else begin
          widx_s = widx_r + 3'd1;
        end
      end else begin
        widx_s = widx_r;
      end
    end
  end

  // Drain FSM next state plus the registered-output next values.
  always_comb begin
    state_s     = state_r;
    out_valid_s = 1'b0;
    out_data_s  = 32'h0000_0000;
    out_last_s  = 1'b0;
    head_idx_s  = rd_ptr_s[AW-1:0];
    if (accept_s && (wr_ptr_r[AW-1:0] == head_idx_s)) begin
      head_rec_s = new_rec_s;
    end else begin
      head_rec_s = mem_r[head_idx_s];
    end
    if (clear) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_s = ST_SEND;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_SEND: begin
          if (pop_s && (count_s == {(AW+1){1'b0}})) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_SEND;
          end
        end
        default: state_s = ST_EMPTY;
      endcase
    end
    if (state_s == ST_SEND) begin
      out_valid_s = 1'b1;
      out_data_s  = word_sel(head_rec_s, widx_s);
      out_last_s  = (widx_s == 3'd4);
    end else begin
      out_valid_s = 1'b0;
      out_data_s  = 32'h0000_0000;
      out_last_s  = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      state_r     <= ST_EMPTY;
      widx_r      <= 3'd0;
      wr_ptr_r    <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      count_r     <= {(AW+1){1'b0}};
      seq_r       <= 16'h0000;
      overflow_r  <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      widx_r      <= widx_s;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      seq_r       <= seq_s;
      overflow_r  <= overflow_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= new_rec_s;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign count     = count_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_zpu_trace_buffer.sv
// Scoreboard bench for zpu_trace_buffer: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted stream word.
module tb_zpu_trace_buffer;

  logic         clk;
  logic         rstin;
  logic [136:0] dbg_i;
  logic         capture_en;
  logic         clear;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [4:0]   count;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb[$];        // {last, data}
  logic [15:0] seq_model;

  zpu_trace_buffer #(.DEPTH(16)) dut (
    .clk(clk), .rstin(rstin), .dbg_i(dbg_i), .capture_en(capture_en),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .count(count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the five expected words of a record stamped with seq s.
  task automatic push_exp(input logic [31:0] pc, input logic [31:0] sp,
                          input logic [31:0] tos, input logic [31:0] nos,
                          input logic [7:0] inst, input logic [15:0] s);
    sb.push_back({1'b0, pc});
    sb.push_back({1'b0, sp});
    sb.push_back({1'b0, tos});
    sb.push_back({1'b0, nos});
    sb.push_back({1'b1, 8'hA5, s, inst});
  endtask

  task automatic drive_rec(input logic [31:0] pc, input logic [31:0] sp,
                           input logic [31:0] tos, input logic [31:0] nos,
                           input logic [7:0] inst);
    dbg_i = {1'b1, inst, nos, tos, sp, pc};
  endtask

  // One accepted capture into a non-full FIFO, with expectation pushed.
  task automatic send_rec(input logic [31:0] pc, input logic [31:0] sp,
                          input logic [31:0] tos, input logic [31:0] nos,
                          input logic [7:0] inst);
    push_exp(pc, sp, tos, nos, inst, seq_model);
    seq_model = seq_model + 16'd1;
    drive_rec(pc, sp, tos, nos, inst);
    tick();
    dbg_i[136] = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int k;
    k = 0;
    while ((out_valid || sb.size() != 0) && k < max_cycles) begin
      tick();
      k++;
    end
    chk({name, "_drained"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  // Monitor: a word is consumed on the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rstin && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra: got word %0h last %0b with nothing expected", out_data, out_last);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({out_last, out_data} !== e) begin
          n_fail++;
          $display("FAIL stream_word: got %0h last %0b expected %0h last %0b",
                   out_data, out_last, e[31:0], e[32]);
        end
      end
    end
  end

  initial begin
    rstin = 1'b0; dbg_i = '0; capture_en = 1'b1; clear = 1'b0; out_ready = 1'b0;
    seq_model = 16'd0;
    #22 rstin = 1'b1;
    tick();
    // Reset values
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    // Single record, w4 expected 0xA500003C
    out_ready = 1'b1;
    send_rec(32'h100, 32'h7FF8, 32'd3, 32'd4, 8'h3C);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_count", {27'd0, count}, 32'd1);
    wait_idle("single", 20);
    chk("single_count_end", {27'd0, count}, 32'd0);

    // Backpressure: head word held for 10 cycles
    out_ready = 1'b0;
    send_rec(32'h200, 32'h11, 32'h22, 32'h33, 8'h44);
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", out_data, 32'h200);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("bp", 20);

    // Gating: nothing captured, seq unchanged
    capture_en = 1'b0;
    drive_rec(32'h300, 32'h1, 32'h2, 32'h3, 8'h55);
    tick(); tick(); tick();
    dbg_i[136] = 1'b0;
    capture_en = 1'b1;
    chk("gate_count", {27'd0, count}, 32'd0);
    chk("gate_valid", {31'd0, out_valid}, 32'd0);
    send_rec(32'h400, 32'h5, 32'h6, 32'h7, 8'h66);   // seq 2
    wait_idle("gate", 20);

    // Async reset mid-stream
    send_rec(32'h500, 32'h8, 32'h9, 32'hA, 8'h77);
    tick(); tick();
    #2 rstin = 1'b0; out_ready = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_last", {31'd0, out_last}, 32'd0);
    chk("arst_count", {27'd0, count}, 32'd0);
    sb.delete();
    seq_model = 16'd0;
    @(negedge clk);
    rstin = 1'b1;
    tick();

    // Overflow: 18 consecutive captures, 16 stored
    for (int i = 0; i < 18; i++) begin
      if (i < 16) push_exp(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 32'h4000 + i, 8'(i), 16'(i));
      drive_rec(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 32'h4000 + i, 8'(i));
      tick();
    end
    dbg_i[136] = 1'b0;
    seq_model = 16'd18;
    chk("ovf_count", {27'd0, count}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);

    // Full + pop in the same cycle: capture coincides with w4 handshake
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    push_exp(32'h99, 32'h98, 32'h97, 32'h96, 8'hEE, seq_model);
    seq_model = seq_model + 16'd1;
    drive_rec(32'h99, 32'h98, 32'h97, 32'h96, 8'hEE);
    tick();
    dbg_i[136] = 1'b0;
    chk("fullpop_count", {27'd0, count}, 32'd16);
    chk("fullpop_ovf", {31'd0, overflow}, 32'd1);
    wait_idle("fullpop", 120);

    // Clear at widx 2
    out_ready = 1'b0;
    send_rec(32'h600, 32'hB, 32'hC, 32'hD, 8'h88);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    seq_model = 16'd0;
    chk("clr_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_count", {27'd0, count}, 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    send_rec(32'h700, 32'hE, 32'hF, 32'h10, 8'h99);   // seq 0
    wait_idle("clr", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
